// File: rtl/tweet_serializer.sv
// UART 8N1 transmitter fed from a small power-of-two byte FIFO.
// Line idles high; frames are start(0), 8 data bits LSB first, then stop(1).
module tweet_serializer #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          sysclk,
    input  logic                          reset,
    input  logic                          active,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          serialOut,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CPB = CLK_FREQ / BAUD;
    localparam int TW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam logic [TW-1:0] T_LAST = TW'(CPB - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state, state_nx;
    logic [TW-1:0]  timer;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           full, empty, push, pop, tick;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign tick  = (state != IDLE) && (timer == T_LAST);
    // Push uses the pre-edge full flag, so a same-edge pop never frees a slot early.
    assign push  = data_valid && !full;
    assign pop   = active && !empty && ((state == IDLE) || (state == STOP && tick));

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pop) state_nx = START;
            START:   if (tick) state_nx = DATA;
            DATA:    if (tick && bit_idx == 3'd7) state_nx = STOP;
            STOP:    if (tick) state_nx = pop ? START : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        serialOut  = 1'b1;
        busy       = (state != IDLE);
        data_ready = !full;
        fifo_count = count;
        case (state)
            START:   serialOut = 1'b0;
            DATA:    serialOut = shift[0];
            default: serialOut = 1'b1;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            timer <= (state == IDLE || tick) ? '0 : timer + TW'(1);
            if (state == START && tick)
                bit_idx <= '0;
            else if (state == DATA && tick)
                bit_idx <= bit_idx + 3'd1;
            if (pop)
                shift <= mem[rd_ptr];
            else if (state == DATA && tick)
                shift <= {1'b0, shift[7:1]};
        end
    end

    always_ff @(posedge sysclk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_tweet_serializer.sv
// Bench for tweet_serializer: queue-based line model compared every cycle,
// an independent UART receiver decoding the line, and directed literal checks.
module tb_tweet_serializer;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       sysclk = 1'b0;
    logic       reset = 1'b1;
    logic       active = 1'b0;
    logic       data_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_ready, serialOut, busy;
    logic [2:0] fifo_count;

    int total = 0;
    int bad = 0;

    tweet_serializer #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(DEPTH)) dut (
        .sysclk(sysclk), .reset(reset), .active(active), .data_in(data_in),
        .data_valid(data_valid), .data_ready(data_ready), .serialOut(serialOut),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO as a queue, current frame as (byte, cycles since frame start).
    logic [7:0] mq[$];
    logic [7:0] sent_q[$];
    logic [7:0] m_byte = 8'h00;
    bit         m_in = 1'b0;
    int         m_pos = 0;

    always @(posedge sysclk or negedge reset) begin
        bit m_push, m_pop;
        int sz;
        if (!reset) begin
            mq.delete();
            sent_q.delete();
            m_in = 1'b0;
            m_pos = 0;
        end else begin
            sz = mq.size();
            m_push = data_valid && (sz < DEPTH);
            m_pop  = active && (sz > 0) && (!m_in || m_pos == 10*CPB-1);
            if (m_in && m_pos == 10*CPB-1 && !m_pop) m_in = 1'b0;
            else if (m_in) m_pos++;
            if (m_pop) begin
                m_byte = mq.pop_front();
                sent_q.push_back(m_byte);
                m_pos = 0;
                m_in = 1'b1;
            end
            if (m_push) mq.push_back(data_in);
        end
    end

    function automatic logic exp_line();
        logic [2:0] bi;
        if (!m_in) return 1'b1;
        if (m_pos < CPB) return 1'b0;
        if (m_pos < 9*CPB) begin
            bi = 3'(m_pos/CPB - 1);
            return m_byte[bi];
        end
        return 1'b1;
    endfunction

    always @(negedge sysclk) begin
        check("serialOut", serialOut, exp_line());
        check("busy", busy, m_in);
        check("fifo_count", fifo_count, mq.size());
        check("data_ready", data_ready, mq.size() < DEPTH);
    end

    // Independent receiver: samples mid-bit, compares each byte against what the model sent.
    logic [7:0] rx_log[$];
    bit         rx_on = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;

    always @(negedge sysclk) begin
        int idx;
        logic [7:0] want;
        if (!reset) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (serialOut == 1'b0) begin
                rx_on = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB/2) begin
                idx = rx_cnt / CPB;
                if (idx == 0) check("rx_start", serialOut, 0);
                else if (idx <= 8) rx_sh[3'(idx-1)] = serialOut;
                else begin
                    check("rx_stop", serialOut, 1);
                    rx_log.push_back(rx_sh);
                    want = (sent_q.size() > 0) ? sent_q.pop_front() : ~rx_sh;
                    check("rx_byte", rx_sh, want);
                    rx_on = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge sysclk);
        #2;
    endtask

    task automatic push_one(input logic [7:0] b);
        int n;
        bit rdy;
        n = 0;
        data_in = b;
        data_valid = 1'b1;
        do begin
            rdy = data_ready;
            step();
            n++;
        end while (!rdy && n < 2000);
        data_valid = 1'b0;
        check("push_timeout", rdy, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || fifo_count != 0) && n < budget) begin
            step();
            n++;
        end
        check("idle_timeout", busy | (fifo_count != 0), 0);
    endtask

    initial begin
        logic [7:0] a[12];
        logic [7:0] b6[6];
        logic       p55[8];
        int n, rxn, base;

        p55 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        #1 reset = 1'b0;
        repeat (3) step();
        check("rst_serial", serialOut, 1);
        check("rst_ready", data_ready, 1);
        reset = 1'b1;
        step();

        // Single 0x55 into an idle block.
        active = 1'b1;
        push_one(8'h55);
        check("t1_pre_line", serialOut, 1);
        step();
        check("t1_fall", serialOut, 0);
        check("t1_busy", busy, 1);
        repeat (8) step();
        check("t1_start", serialOut, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (16) step();
            check("t1_bit", serialOut, p55[i]);
        end
        repeat (16) step();
        check("t1_stop", serialOut, 1);
        repeat (7) step();
        check("t1_busy_end", busy, 1);
        step();
        check("t1_busy_off", busy, 0);

        // Three back-to-back frames without a gap.
        push_one(8'hA3);
        push_one(8'h0F);
        push_one(8'hFF);
        n = 0;
        while (busy && n < 1000) begin
            step();
            n++;
        end
        check("t2_span", n, 479);
        base = rx_log.size() - 3;
        check("t2_rx0", rx_log[base], 8'hA3);
        check("t2_rx1", rx_log[base+1], 8'h0F);
        check("t2_rx2", rx_log[base+2], 8'hFF);

        // Fill while inactive: only DEPTH bytes land.
        active = 1'b0;
        for (int j = 0; j < 6; j++) b6[j] = 8'($urandom);
        data_valid = 1'b1;
        for (int j = 0; j < 6; j++) begin
            data_in = b6[j];
            step();
        end
        data_valid = 1'b0;
        check("t3_count", fifo_count, 4);
        check("t3_ready", data_ready, 0);
        active = 1'b1;
        wait_idle(1000);
        base = rx_log.size() - 4;
        for (int j = 0; j < 4; j++) check("t3_order", rx_log[base+j], b6[j]);

        // active dropped mid-frame.
        push_one(8'h81);
        repeat (48) step();
        push_one(8'h3C);
        active = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
        check("t4_line", serialOut, 1);
        check("t4_count", fifo_count, 1);
        check("t4_rx", rx_log[rx_log.size()-1], 8'h81);
        repeat (30) step();
        check("t4_hold", busy, 0);
        active = 1'b1;
        wait_idle(500);

        // Reset mid-DATA with two bytes queued.
        push_one(8'h11);
        push_one(8'h22);
        push_one(8'h33);
        repeat (40) step();
        reset = 1'b0;
        #1;
        check("t5_line", serialOut, 1);
        check("t5_count", fifo_count, 0);
        check("t5_busy", busy, 0);
        step();
        reset = 1'b1;
        rxn = rx_log.size();
        repeat (400) step();
        check("t5_quiet", busy, 0);
        check("t5_rx", rx_log.size(), rxn);

        // Push+pop on the same edge at count 2, then wrap the pointers.
        for (int j = 0; j < 12; j++) a[j] = 8'($urandom);
        push_one(a[0]);
        push_one(a[1]);
        push_one(a[2]);
        repeat (158) step();
        data_in = a[3];
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        check("t6_count", fifo_count, 2);
        for (int j = 4; j < 12; j++) push_one(a[j]);
        wait_idle(5000);
        base = rx_log.size() - 12;
        for (int j = 0; j < 12; j++) check("t6_order", rx_log[base+j], a[j]);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            active = ($urandom % 8) != 0;
            data_valid = ($urandom % 3) == 0;
            data_in = 8'($urandom);
            step();
        end
        data_valid = 1'b0;
        active = 1'b1;
        wait_idle(5000);
        repeat (20) step();
        check("sent_drain", sent_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
